// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates from hs/vs, checks line and frame
// timing, tracks lock over clean frames and emits a qualified pixel stream with error status.
module vga_rx_monitor #(
    parameter int unsigned HOR_TOTAL   = 1056,
    parameter int unsigned HOR_SYNC    = 128,
    parameter int unsigned HOR_BACK    = 88,
    parameter int unsigned HOR_ACTIVE  = 800,
    parameter int unsigned VER_TOTAL   = 628,
    parameter int unsigned VER_SYNC    = 4,
    parameter int unsigned VER_BACK    = 23,
    parameter int unsigned VER_ACTIVE  = 600,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_done,
    output logic        locked,
    output logic        timing_err,
    output logic [7:0]  err_cnt
);

    localparam int unsigned PW  = 11;
    localparam int unsigned CW  = 4;
    localparam int unsigned EW  = 8;
    localparam int unsigned RGBW = 12;

    localparam logic [PW-1:0] POS_MAX = '1;
    localparam logic [PW-1:0] H_LAST  = PW'(HOR_TOTAL - 1);
    localparam logic [PW-1:0] H_SYNC  = PW'(HOR_SYNC);
    localparam logic [PW-1:0] H_START = PW'(HOR_SYNC + HOR_BACK);
    localparam logic [PW-1:0] H_END   = PW'(HOR_SYNC + HOR_BACK + HOR_ACTIVE - 1);
    localparam logic [PW-1:0] V_TOTAL = PW'(VER_TOTAL);
    localparam logic [PW-1:0] V_SYNC  = PW'(VER_SYNC);
    localparam logic [PW-1:0] V_START = PW'(VER_SYNC + VER_BACK);
    localparam logic [PW-1:0] V_END   = PW'(VER_SYNC + VER_BACK + VER_ACTIVE - 1);
    localparam logic [CW-1:0] LOCK_N  = CW'(LOCK_FRAMES);
    localparam logic [EW-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t state_q, state_nx;
    logic [CW-1:0] clean_q, clean_nx;

    logic            hs_s1, vs_s1, hs_s1_d, vs_s1_d;
    logic [RGBW-1:0] rgb_s1;
    logic [PW-1:0]   h_q, v_q, line_cnt_q;
    logic            v_arm_q, h_seen_q, frame_err_q;

    logic          hs_rise_c, hs_fall_c, vs_rise_c, vs_fall_c;
    logic [PW-1:0] h_pos_c, v_pos_c, lc_incl_c;
    logic          check_v_c, window_c, err_c;

    logic            pix_valid_nx, frame_done_nx, locked_nx, timing_err_nx;
    logic [PW-1:0]   pix_x_nx, pix_y_nx;
    logic [RGBW-1:0] pix_rgb_nx;
    logic [EW-1:0]   err_cnt_nx;

    // Stage 1 input capture plus previous sample for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_s1   <= 1'b0;
            vs_s1   <= 1'b0;
            hs_s1_d <= 1'b0;
            vs_s1_d <= 1'b0;
            rgb_s1  <= '0;
        end else begin
            hs_s1   <= hs;
            vs_s1   <= vs;
            hs_s1_d <= hs_s1;
            vs_s1_d <= vs_s1;
            rgb_s1  <= {r, g, b};
        end
    end

    assign hs_rise_c = hs_s1 & ~hs_s1_d;
    assign hs_fall_c = ~hs_s1 & hs_s1_d;
    assign vs_rise_c = vs_s1 & ~vs_s1_d;
    assign vs_fall_c = ~vs_s1 & vs_s1_d;
    assign check_v_c = (state_q != S_HUNT);

    // Coordinates of the sample currently in stage 1
    always_comb begin
        h_pos_c = h_q;
        if (hs_rise_c) begin
            h_pos_c = '0;
        end else if (h_q != POS_MAX) begin
            h_pos_c = h_q + PW'(1);
        end

        v_pos_c = v_q;
        if (hs_rise_c) begin
            if (v_arm_q || vs_rise_c) begin
                v_pos_c = '0;
            end else if (v_q != POS_MAX) begin
                v_pos_c = v_q + PW'(1);
            end
        end

        lc_incl_c = line_cnt_q;
        if (hs_rise_c && (line_cnt_q != POS_MAX)) begin
            lc_incl_c = line_cnt_q + PW'(1);
        end
    end

    // Line count includes an hs rise coincident with the checking vs edge
    assign err_c = (hs_rise_c & h_seen_q & (h_q != H_LAST))
                 | (hs_fall_c & h_seen_q & (h_pos_c != H_SYNC))
                 | (vs_rise_c & check_v_c & (lc_incl_c != V_TOTAL))
                 | (vs_fall_c & check_v_c & (lc_incl_c != V_SYNC));

    assign window_c = (h_pos_c >= H_START) && (h_pos_c <= H_END)
                   && (v_pos_c >= V_START) && (v_pos_c <= V_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q         <= '0;
            v_q         <= '0;
            line_cnt_q  <= '0;
            v_arm_q     <= 1'b0;
            h_seen_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            h_q         <= h_pos_c;
            v_q         <= v_pos_c;
            line_cnt_q  <= vs_rise_c ? '0 : lc_incl_c;
            v_arm_q     <= hs_rise_c ? 1'b0 : (v_arm_q | vs_rise_c);
            h_seen_q    <= h_seen_q | hs_rise_c;
            frame_err_q <= vs_rise_c ? 1'b0 : (frame_err_q | err_c);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HUNT;
            clean_q <= '0;
        end else begin
            state_q <= state_nx;
            clean_q <= clean_nx;
        end
    end

    // FSM next state; a frame is clean only if neither it nor its closing vs rise failed
    always_comb begin
        state_nx = state_q;
        clean_nx = clean_q;
        unique case (state_q)
            S_HUNT: begin
                if (vs_rise_c) begin
                    state_nx = S_ACQ;
                    clean_nx = '0;
                end
            end
            S_ACQ: begin
                if (err_c) begin
                    clean_nx = '0;
                end else if (vs_rise_c && !frame_err_q) begin
                    if ((clean_q + CW'(1)) == LOCK_N) begin
                        state_nx = S_LOCKED;
                        clean_nx = '0;
                    end else begin
                        clean_nx = clean_q + CW'(1);
                    end
                end
            end
            S_LOCKED: begin
                if (err_c) begin
                    state_nx = S_HUNT;
                end
            end
            default: begin
                state_nx = S_HUNT;
                clean_nx = '0;
            end
        endcase
    end

    // FSM outputs; pixel fields hold while no valid pixel is presented
    always_comb begin
        locked_nx     = (state_nx == S_LOCKED);
        pix_valid_nx  = window_c && locked_nx;
        frame_done_nx = vs_rise_c && locked_nx;
        timing_err_nx = err_c;
        err_cnt_nx    = err_cnt;
        pix_x_nx      = pix_x;
        pix_y_nx      = pix_y;
        pix_rgb_nx    = pix_rgb;
        if (err_c && (err_cnt != ERR_MAX)) begin
            err_cnt_nx = err_cnt + EW'(1);
        end
        if (pix_valid_nx) begin
            pix_x_nx   = h_pos_c - H_START;
            pix_y_nx   = v_pos_c - V_START;
            pix_rgb_nx = rgb_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_rgb    <= '0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
            err_cnt    <= '0;
        end else begin
            pix_valid  <= pix_valid_nx;
            pix_x      <= pix_x_nx;
            pix_y      <= pix_y_nx;
            pix_rgb    <= pix_rgb_nx;
            frame_done <= frame_done_nx;
            locked     <= locked_nx;
            timing_err <= timing_err_nx;
            err_cnt    <= err_cnt_nx;
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Scoreboard bench for vga_rx_monitor using a scaled-down timing (40x20 total, 24x12 active).
module tb_vga_rx_monitor;

    localparam int HT  = 40;
    localparam int HSW = 4;
    localparam int HB  = 4;
    localparam int HA  = 24;
    localparam int VT  = 20;
    localparam int VSW = 2;
    localparam int VB  = 3;
    localparam int VA  = 12;
    localparam int H0  = HSW + HB;
    localparam int V0  = VSW + VB;
    localparam int PIX_PER_FRAME = HA * VA;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [11:0] rgb;
    } pix_t;

    typedef struct packed {
        logic       te;
        logic       fd;
        logic       lk;
        logic [7:0] ec;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic [3:0]  r = '0;
    logic [3:0]  g = '0;
    logic [3:0]  b = '0;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic [11:0] pix_rgb;
    logic        frame_done;
    logic        locked;
    logic        timing_err;
    logic [7:0]  err_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    int   pix_seen = 0;
    int   salt = 0;
    pix_t pix_q[$];
    ev_t  ev_q[$];

    vga_rx_monitor #(
        .HOR_TOTAL(HT), .HOR_SYNC(HSW), .HOR_BACK(HB), .HOR_ACTIVE(HA),
        .VER_TOTAL(VT), .VER_SYNC(VSW), .VER_BACK(VB), .VER_ACTIVE(VA),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_done(frame_done), .locked(locked), .timing_err(timing_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_ev(input logic te, input logic fd, input logic lk, input int ec);
        ev_t e;
        e.te = te;
        e.fd = fd;
        e.lk = lk;
        e.ec = 8'(ec);
        ev_q.push_back(e);
    endtask

    task automatic drive(input logic hv, input logic vv, input logic [11:0] c);
        @(negedge clk);
        hs = hv;
        vs = vv;
        {r, g, b} = c;
    endtask

    // One line; expected pixels are queued as the active samples are driven
    task automatic send_line(input int len, input int hsw, input int vl, input logic vsv,
                             input bit ex);
        pix_t        pe;
        logic [11:0] c;
        for (int h = 0; h < len; h++) begin
            c = 12'(h * 5 + vl * 17 + salt);
            drive(h < hsw, vsv, c);
            if (ex && h >= H0 && h < H0 + HA && vl >= V0 && vl < V0 + VA) begin
                pe.x   = 11'(h - H0);
                pe.y   = 11'(vl - V0);
                pe.rgb = c;
                pix_q.push_back(pe);
            end
        end
    endtask

    task automatic send_frame(input int lines, input int bad_line, input int bad_len,
                              input int bad_hsw, input bit ex, input int pix_stop);
        salt = salt + 3;
        for (int l = 0; l < lines; l++) begin
            send_line((l == bad_line) ? bad_len : HT, (l == bad_line) ? bad_hsw : HSW,
                      l, l < VSW, ex && (l < pix_stop));
        end
    endtask

    // Monitor: pops expected pixels / status events whenever the DUT presents them
    initial begin
        pix_t pe;
        ev_t  e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (pix_valid) begin
                    pix_seen++;
                    if (pix_q.size() == 0) begin
                        chk("pix_unexpected", 32'(pix_valid), 32'd0);
                    end else begin
                        pe = pix_q.pop_front();
                        chk("pix_x", 32'(pix_x), 32'(pe.x));
                        chk("pix_y", 32'(pix_y), 32'(pe.y));
                        chk("pix_rgb", 32'(pix_rgb), 32'(pe.rgb));
                    end
                end
                if (timing_err || frame_done) begin
                    if (ev_q.size() == 0) begin
                        chk("event_unexpected", {30'd0, timing_err, frame_done}, 32'd0);
                    end else begin
                        e = ev_q.pop_front();
                        chk("timing_err", 32'(timing_err), 32'(e.te));
                        chk("frame_done", 32'(frame_done), 32'(e.fd));
                        chk("locked", 32'(locked), 32'(e.lk));
                        chk("err_cnt", 32'(err_cnt), 32'(e.ec));
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix_x"}, 32'(pix_x), 32'd0);
        chk({tag, "_pix_y"}, 32'(pix_y), 32'd0);
        chk({tag, "_pix_rgb"}, 32'(pix_rgb), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_timing_err"}, 32'(timing_err), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        int base;
        int k;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Two clean frames, lock on the third vs rise
        send_frame(VT, -1, 0, 0, 1'b0, VT);
        send_frame(VT, -1, 0, 0, 1'b0, VT);
        chk("locked_before_lock", 32'(locked), 32'd0);
        push_ev(1'b0, 1'b1, 1'b1, 0);
        base = pix_seen;
        send_frame(VT, -1, 0, 0, 1'b1, VT);
        chk("pix_per_frame_f2", 32'(pix_seen - base), 32'(PIX_PER_FRAME));
        chk("locked_after_f2", 32'(locked), 32'd1);
        chk("err_cnt_after_f2", 32'(err_cnt), 32'd0);

        // Short line while locked; relock after two clean frames
        push_ev(1'b0, 1'b1, 1'b1, 0);
        push_ev(1'b1, 1'b0, 1'b0, 1);
        send_frame(VT, 8, HT - 1, HSW, 1'b1, 9);
        chk("locked_after_short_line", 32'(locked), 32'd0);
        send_frame(VT, -1, 0, 0, 1'b0, VT);
        send_frame(VT, -1, 0, 0, 1'b0, VT);
        push_ev(1'b0, 1'b1, 1'b1, 1);
        base = pix_seen;
        send_frame(VT, -1, 0, 0, 1'b1, VT);
        chk("pix_per_frame_f6", 32'(pix_seen - base), 32'(PIX_PER_FRAME));

        // Frame one line short while locked; error lands on the next vs rise
        push_ev(1'b0, 1'b1, 1'b1, 1);
        push_ev(1'b1, 1'b0, 1'b0, 2);
        base = pix_seen;
        send_frame(VT - 1, -1, 0, 0, 1'b1, VT);
        chk("pix_per_frame_f7", 32'(pix_seen - base), 32'(PIX_PER_FRAME));
        send_frame(VT, -1, 0, 0, 1'b0, VT);
        chk("locked_after_short_frame", 32'(locked), 32'd0);

        // Narrow hs during acquisition delays lock by one frame
        push_ev(1'b1, 1'b0, 1'b0, 3);
        send_frame(VT, 6, HT, HSW - 1, 1'b0, VT);
        send_frame(VT, -1, 0, 0, 1'b0, VT);
        send_frame(VT, -1, 0, 0, 1'b0, VT);
        chk("locked_delayed", 32'(locked), 32'd0);
        push_ev(1'b0, 1'b1, 1'b1, 3);
        send_frame(8, -1, 0, 0, 1'b1, VT);
        send_line(3, HSW, 8, 1'b0, 1'b0);
        chk("locked_before_rst", 32'(locked), 32'd1);
        chk("err_cnt_before_rst", 32'(err_cnt), 32'd3);

        // Asynchronous reset mid-line
        #2 rst = 1'b0;
        hs = 1'b0;
        vs = 1'b0;
        #1 check_all_zero("async_rst");
        chk("pix_q_drained", 32'(pix_q.size()), 32'd0);
        chk("ev_q_drained", 32'(ev_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 301 forced errors from 4-clock hs periods; count saturates at 255
        k = 0;
        for (int p = 0; p < 151; p++) begin
            if (p > 0) begin
                k++;
                push_ev(1'b1, 1'b0, 1'b0, (k > 255) ? 255 : k);
            end
            drive(1'b1, 1'b0, 12'h0);
            drive(1'b1, 1'b0, 12'h0);
            k++;
            push_ev(1'b1, 1'b0, 1'b0, (k > 255) ? 255 : k);
            drive(1'b0, 1'b0, 12'h0);
            drive(1'b0, 1'b0, 12'h0);
        end
        repeat (4) @(negedge clk);
        chk("err_cnt_saturated", 32'(err_cnt), 32'd255);
        chk("locked_after_errors", 32'(locked), 32'd0);
        chk("ev_q_empty_end", 32'(ev_q.size()), 32'd0);
        chk("pix_q_empty_end", 32'(pix_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
